// File: rtl/stage_memory0_arb_pkg.sv
// Shared types and constants for the memory-stage-0 slice: exception
// causes, access-width encodings and satp field positions.
package stage_memory0_arb_pkg;

  typedef enum logic [3:0] {
    ECAUSE_INST_MISALIGNED  = 4'd0,
    ECAUSE_INST_FAULT       = 4'd1,
    ECAUSE_ILLEGAL_INST     = 4'd2,
    ECAUSE_BREAKPOINT       = 4'd3,
    ECAUSE_LOAD_MISALIGNED  = 4'd4,
    ECAUSE_LOAD_FAULT       = 4'd5,
    ECAUSE_STORE_MISALIGNED = 4'd6,
    ECAUSE_STORE_FAULT      = 4'd7,
    ECAUSE_ECALL_U          = 4'd8,
    ECAUSE_ECALL_S          = 4'd9,
    ECAUSE_INST_PAGE_FAULT  = 4'd12,
    ECAUSE_LOAD_PAGE_FAULT  = 4'd13,
    ECAUSE_STORE_PAGE_FAULT = 4'd15
  } ecause_t;

  localparam logic [1:0] MEM_W_BYTE = 2'd0;
  localparam logic [1:0] MEM_W_HALF = 2'd1;
  localparam logic [1:0] MEM_W_WORD = 2'd2;

  localparam int SATP_MODE_BIT = 31;
  localparam int SATP_ASID_LSB = 22;

  // A half access must be 2-byte aligned, a word access 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    return ((width == MEM_W_HALF) && addr_lo[0]) ||
           ((width == MEM_W_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/stage_memory0_arb_mem_arb_rr.sv
// Small N-way arbiter: fixed priority (lowest index) or round-robin, with a
// one-hot grant and its binary index. Grants complete in the cycle issued.
module mem_arb_rr
  import stage_memory0_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int MODE  = 0,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_core,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] rr;
  logic             found;
  int               cand;

  // Search requesters starting at the pointer (round-robin) or at 0 (fixed).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (MODE == 1) ? int'(rr) + k : k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

  // Move the pointer just past the channel granted; hold it when idle.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      rr <= '0;
    end else if (advance && found) begin
      rr <= (int'(idx) == N - 1) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/stage_memory0_arb.sv
// Memory stage 0: registers the execute-stage memory op, flags misaligned
// accesses, and shares the dcache request port between that op and the
// auxiliary read channels (aux always wins). A source tag tells memory1
// who owns the access.
module stage_memory0_arb
  import stage_memory0_arb_pkg::*;
#(
  parameter int NUM_AUX  = 2,
  parameter int ARB_MODE = 0,
  parameter int ASID_W   = 9,
  parameter int SRC_W    = $clog2(NUM_AUX + 1)
) (
  input  logic                  clk_core,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_exc,
  input  ecause_t               ex_exc_cause,
  input  logic [29:0]           ex_pc,
  input  logic [31:0]           ex_data0,
  input  logic [31:0]           ex_data1,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_extend,
  input  logic [1:0]            ex_mem_width,
  input  logic [4:0]            ex_wb_reg,
  output logic                  mem0_stall,
  input  logic [NUM_AUX-1:0]    aux_req,
  input  logic [NUM_AUX-1:0]    aux_trans,
  input  logic [NUM_AUX*30-1:0] aux_addr,
  output logic [NUM_AUX-1:0]    aux_gnt,
  input  logic                  csr_kill,
  input  logic [31:0]           csr_satp,
  output logic                  mem0_dc_read,
  output logic                  mem0_dc_trans,
  output logic [ASID_W-1:0]     mem0_dc_asid,
  output logic [29:0]           mem0_dc_addr,
  output logic [31:0]           mem0_fwd_data,
  input  logic                  mem1_stall,
  output logic                  mem0_valid,
  output logic                  mem0_exc,
  output ecause_t               mem0_exc_cause,
  output logic [29:0]           mem0_pc,
  output logic [SRC_W-1:0]      mem0_src,
  output logic                  mem0_read,
  output logic                  mem0_write,
  output logic                  mem0_extend,
  output logic [1:0]            mem0_width,
  output logic [31:0]           mem0_addr,
  output logic [31:0]           mem0_wdata,
  output logic [4:0]            mem0_wb_reg
);

  localparam int IDX_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;

  logic              op_valid;
  logic              op_exc;
  logic              mis_exc;
  logic              load_en;
  logic              any_req;
  logic              any_gnt;
  logic              satp_mode;
  logic [ASID_W-1:0] satp_asid;
  logic [IDX_W-1:0]  gnt_idx;
  logic [29:0]       aux_sel_addr;
  logic              unused_satp;

  assign satp_mode    = csr_satp[SATP_MODE_BIT];
  assign satp_asid    = csr_satp[SATP_ASID_LSB +: ASID_W];
  assign unused_satp  = ^csr_satp;
  assign any_req      = |aux_req;
  assign any_gnt      = |aux_gnt;
  assign aux_sel_addr = aux_addr[30*int'(gnt_idx) +: 30];

  assign mis_exc = ex_valid & ~ex_exc & (ex_mem_read | ex_mem_write) &
                   is_misaligned(ex_mem_width, ex_data0[1:0]);

  assign mem0_stall = (op_valid | op_exc) & (mem1_stall | any_req);
  assign load_en    = ~mem0_stall | csr_kill;
  assign mem0_valid = ((op_valid & ~op_exc & ~mem0_stall) | any_gnt) & ~csr_kill;
  assign mem0_exc   = op_exc & ~any_gnt & ~csr_kill;

  mem_arb_rr #(
    .N    (NUM_AUX),
    .MODE (ARB_MODE),
    .IDX_W(IDX_W)
  ) u_arb (
    .clk_core(clk_core),
    .reset   (reset),
    .req     (aux_req),
    .advance (any_req),
    .gnt     (aux_gnt),
    .idx     (gnt_idx)
  );

  // Pipeline register: capture the execute op whenever not stalled or on a kill.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      op_valid       <= 1'b0;
      op_exc         <= 1'b0;
      mem0_exc_cause <= ecause_t'(4'd0);
      mem0_pc        <= '0;
      mem0_fwd_data  <= '0;
      mem0_wdata     <= '0;
      mem0_read      <= 1'b0;
      mem0_write     <= 1'b0;
      mem0_extend    <= 1'b0;
      mem0_width     <= '0;
      mem0_wb_reg    <= '0;
    end else if (load_en) begin
      op_valid       <= ex_valid;
      op_exc         <= ex_exc | mis_exc;
      mem0_exc_cause <= mis_exc ? (ex_mem_write ? ECAUSE_STORE_MISALIGNED : ECAUSE_LOAD_MISALIGNED)
                                : ex_exc_cause;
      mem0_pc        <= ex_pc;
      mem0_fwd_data  <= ex_data0;
      mem0_wdata     <= ex_data1;
      mem0_read      <= ex_mem_read;
      mem0_write     <= ex_mem_write;
      mem0_extend    <= ex_mem_extend;
      mem0_width     <= ex_mem_width;
      mem0_wb_reg    <= ex_wb_reg;
    end
  end

  // Drive the dcache port from the winning aux channel, else the registered op.
  always_comb begin
    mem0_dc_read  = 1'b0;
    mem0_dc_trans = 1'b0;
    mem0_dc_asid  = '0;
    mem0_dc_addr  = '0;
    mem0_src      = '0;
    mem0_addr     = mem0_fwd_data;
    if (any_req) begin
      mem0_dc_read  = 1'b1;
      mem0_dc_trans = aux_trans[gnt_idx] & satp_mode;
      mem0_dc_asid  = satp_asid;
      mem0_dc_addr  = aux_sel_addr;
      mem0_src      = SRC_W'(gnt_idx) + SRC_W'(1);
      mem0_addr     = {aux_sel_addr, 2'b00};
    end else if (op_valid && !op_exc) begin
      mem0_dc_read  = ~mem0_stall;
      mem0_dc_trans = satp_mode;
      mem0_dc_asid  = satp_asid;
      mem0_dc_addr  = mem0_fwd_data[31:2];
    end
  end

endmodule

// File: tb/tb_stage_memory0_arb.sv
// Bench for stage_memory0_arb: a round-robin instance (NUM_AUX=3) is the
// main subject; a fixed-priority twin shares its inputs for grant checks.
module tb_stage_memory0_arb;
  import stage_memory0_arb_pkg::*;

  localparam logic [31:0] SATP = 32'hE940_0000;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic        exc;
    logic [3:0]  cause;
    logic        dc_read;
    logic        dc_trans;
    logic [29:0] dc_addr;
    logic [1:0]  src;
    logic [2:0]  gnt;
    logic [31:0] addr;
  } obs_t;

  typedef struct packed {
    logic        exc;
    logic [3:0]  cause;
    logic        rd;
    logic        wr;
    logic [1:0]  width;
    logic [31:0] addr;
  } op_t;

  logic clk_core = 1'b0;
  logic reset;
  logic ex_valid, ex_exc, ex_mem_read, ex_mem_write, ex_mem_extend;
  ecause_t ex_exc_cause;
  logic [29:0] ex_pc;
  logic [31:0] ex_data0, ex_data1;
  logic [1:0]  ex_mem_width;
  logic [4:0]  ex_wb_reg;
  logic [2:0]  aux_req;
  logic [2:0]  aux_trans;
  logic [89:0] aux_addr;
  logic        csr_kill, mem1_stall;
  logic [31:0] csr_satp;
  logic [29:0] aux_a [3];

  logic        mem0_stall, mem0_dc_read, mem0_dc_trans, mem0_valid, mem0_exc;
  logic        mem0_read, mem0_write, mem0_extend;
  logic [2:0]  aux_gnt;
  logic [8:0]  mem0_dc_asid;
  logic [29:0] mem0_dc_addr, mem0_pc;
  logic [31:0] mem0_fwd_data, mem0_addr, mem0_wdata;
  ecause_t     mem0_exc_cause;
  logic [1:0]  mem0_src, mem0_width;
  logic [4:0]  mem0_wb_reg;

  logic        f_stall, f_dc_read, f_dc_trans, f_valid, f_exc, f_read, f_write, f_extend;
  logic [2:0]  f_gnt;
  logic [8:0]  f_dc_asid;
  logic [29:0] f_dc_addr, f_pc;
  logic [31:0] f_fwd_data, f_addr, f_wdata;
  ecause_t     f_exc_cause;
  logic [1:0]  f_src, f_width;
  logic [4:0]  f_wb_reg;

  obs_t sb[$];
  int   passes = 0;
  int   total  = 0;

  assign aux_addr  = {aux_a[2], aux_a[1], aux_a[0]};
  assign aux_trans = 3'b101;

  always #5 clk_core = ~clk_core;

  stage_memory0_arb #(.NUM_AUX(3), .ARB_MODE(1), .ASID_W(9)) u_dut (
    .clk_core(clk_core), .reset(reset), .ex_valid(ex_valid), .ex_exc(ex_exc),
    .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc), .ex_data0(ex_data0), .ex_data1(ex_data1),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_extend(ex_mem_extend),
    .ex_mem_width(ex_mem_width), .ex_wb_reg(ex_wb_reg), .mem0_stall(mem0_stall),
    .aux_req(aux_req), .aux_trans(aux_trans), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
    .csr_kill(csr_kill), .csr_satp(csr_satp), .mem0_dc_read(mem0_dc_read),
    .mem0_dc_trans(mem0_dc_trans), .mem0_dc_asid(mem0_dc_asid), .mem0_dc_addr(mem0_dc_addr),
    .mem0_fwd_data(mem0_fwd_data), .mem1_stall(mem1_stall), .mem0_valid(mem0_valid),
    .mem0_exc(mem0_exc), .mem0_exc_cause(mem0_exc_cause), .mem0_pc(mem0_pc),
    .mem0_src(mem0_src), .mem0_read(mem0_read), .mem0_write(mem0_write),
    .mem0_extend(mem0_extend), .mem0_width(mem0_width), .mem0_addr(mem0_addr),
    .mem0_wdata(mem0_wdata), .mem0_wb_reg(mem0_wb_reg)
  );

  stage_memory0_arb #(.NUM_AUX(3), .ARB_MODE(0), .ASID_W(9)) u_fixed (
    .clk_core(clk_core), .reset(reset), .ex_valid(ex_valid), .ex_exc(ex_exc),
    .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc), .ex_data0(ex_data0), .ex_data1(ex_data1),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_extend(ex_mem_extend),
    .ex_mem_width(ex_mem_width), .ex_wb_reg(ex_wb_reg), .mem0_stall(f_stall),
    .aux_req(aux_req), .aux_trans(aux_trans), .aux_addr(aux_addr), .aux_gnt(f_gnt),
    .csr_kill(csr_kill), .csr_satp(csr_satp), .mem0_dc_read(f_dc_read),
    .mem0_dc_trans(f_dc_trans), .mem0_dc_asid(f_dc_asid), .mem0_dc_addr(f_dc_addr),
    .mem0_fwd_data(f_fwd_data), .mem1_stall(mem1_stall), .mem0_valid(f_valid),
    .mem0_exc(f_exc), .mem0_exc_cause(f_exc_cause), .mem0_pc(f_pc),
    .mem0_src(f_src), .mem0_read(f_read), .mem0_write(f_write),
    .mem0_extend(f_extend), .mem0_width(f_width), .mem0_addr(f_addr),
    .mem0_wdata(f_wdata), .mem0_wb_reg(f_wb_reg)
  );

  function automatic obs_t sample();
    obs_t s;
    s.stall = mem0_stall;    s.valid = mem0_valid;      s.exc = mem0_exc;
    s.cause = mem0_exc_cause; s.dc_read = mem0_dc_read; s.dc_trans = mem0_dc_trans;
    s.dc_addr = mem0_dc_addr; s.src = mem0_src;         s.gnt = aux_gnt;
    s.addr = mem0_addr;
    return s;
  endfunction

  // Expected outputs of a registered op issuing with no aux traffic or stall.
  function automatic obs_t model(op_t o);
    obs_t m;
    logic mis;
    mis = ((o.width == 2'd1) && o.addr[0]) || ((o.width == 2'd2) && (o.addr[1:0] != 2'b00));
    m = '0;
    m.addr = o.addr;
    if (o.exc || mis) begin
      m.exc   = 1'b1;
      m.cause = o.exc ? o.cause : (o.wr ? 4'd6 : 4'd4);
    end else begin
      m.valid    = 1'b1;
      m.cause    = o.cause;
      m.dc_read  = 1'b1;
      m.dc_trans = SATP[31];
      m.dc_addr  = o.addr[31:2];
    end
    return m;
  endfunction

  // Expected outputs when aux channel g owns the dcache port.
  function automatic obs_t aux_exp(int g, logic stall, logic valid);
    obs_t m;
    m = '0;
    m.stall    = stall;
    m.valid    = valid;
    m.dc_read  = 1'b1;
    m.dc_trans = aux_trans[g] & SATP[31];
    m.dc_addr  = aux_a[g];
    m.src      = 2'(g + 1);
    m.gnt      = 3'(1 << g);
    m.addr     = {aux_a[g], 2'b00};
    return m;
  endfunction

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic go_idle();
    ex_valid = 1'b0; ex_exc = 1'b0; ex_exc_cause = ecause_t'(4'd0);
    ex_pc = '0; ex_data0 = '0; ex_data1 = '0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_mem_extend = 1'b0; ex_mem_width = '0; ex_wb_reg = '0;
  endtask

  task automatic apply_stimulus(op_t o);
    ex_valid = 1'b1; ex_exc = o.exc; ex_exc_cause = ecause_t'(o.cause);
    ex_pc = o.addr[31:2] ^ 30'h1; ex_data0 = o.addr; ex_data1 = ~o.addr;
    ex_mem_read = o.rd; ex_mem_write = o.wr; ex_mem_extend = 1'b0;
    ex_mem_width = o.width; ex_wb_reg = 5'd7;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    reset = 1'b1;
    csr_kill = 1'b1;
    apply_stimulus('{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h1234_5670});
    step();
    step();
    sb.push_back('0);
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL reset: got %h expected %h", got, exp);
    else passes++;
    total++;
    if (mem0_fwd_data !== 32'h0) $display("[TB] FAIL reset_fwd: got %h expected 0", mem0_fwd_data);
    else passes++;
    step();
    reset = 1'b0;
    csr_kill = 1'b0;
    go_idle();
  endtask

  task automatic test_aligned_load();
    obs_t got, exp;
    op_t  o;
    logic [79:0] ctl_got, ctl_exp;
    o = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_1000};
    step();
    apply_stimulus(o);
    sb.push_back(model(o));
    step();
    go_idle();
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL aligned_load: got %h expected %h", got, exp);
    else passes++;
    ctl_got = {mem0_dc_asid, mem0_pc, mem0_wb_reg, mem0_read, mem0_write, mem0_width, mem0_wdata};
    ctl_exp = {9'h1A5, 30'h401, 5'd7, 1'b1, 1'b0, 2'd2, 32'hFFFF_EFFF};
    total++;
    if (ctl_got !== ctl_exp) $display("[TB] FAIL aligned_ctl: got %h expected %h", ctl_got, ctl_exp);
    else passes++;
    step();
    sb.push_back('0);
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL aligned_idle: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_misalign();
    obs_t got, exp;
    op_t  ops [6];
    ops[0] = '{exc: 1'b0, cause: 4'd0, rd: 1'b0, wr: 1'b1, width: 2'd1, addr: 32'h0000_1001};
    ops[1] = '{exc: 1'b1, cause: 4'd2, rd: 1'b0, wr: 1'b1, width: 2'd1, addr: 32'h0000_1001};
    ops[2] = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_1002};
    ops[3] = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd0, addr: 32'h0000_1003};
    ops[4] = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd1, addr: 32'h0000_1002};
    ops[5] = '{exc: 1'b0, cause: 4'd0, rd: 1'b0, wr: 1'b1, width: 2'd2, addr: 32'h0000_2004};
    for (int i = 0; i <= 6; i++) begin
      step();
      if (i < 6) begin
        apply_stimulus(ops[i]);
        sb.push_back(model(ops[i]));
      end else begin
        go_idle();
      end
      @(negedge clk_core);
      if (i > 0) begin
        exp = sb.pop_front(); got = sample(); total++;
        if (got !== exp) $display("[TB] FAIL misalign_op%0d: got %h expected %h", i - 1, got, exp);
        else passes++;
      end
    end
  endtask

  task automatic test_round_robin();
    obs_t got, exp;
    int   ptr;
    int   g;
    ptr = 0;
    step();
    aux_req = 3'b111;
    for (int c = 0; c < 4; c++) begin
      g = ptr;
      ptr = (g + 1) % 3;
      sb.push_back(aux_exp(g, 1'b0, 1'b1));
      @(negedge clk_core);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) $display("[TB] FAIL rr_grant%0d: got %h expected %h", c, got, exp);
      else passes++;
      total++;
      if (f_gnt !== 3'b001) $display("[TB] FAIL fixed_grant%0d: got %b expected 001", c, f_gnt);
      else passes++;
      step();
    end
    aux_req = 3'b101;
    g = (ptr == 1) ? 2 : 0;
    sb.push_back(aux_exp(g, 1'b0, 1'b1));
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL rr_skip: got %h expected %h", got, exp);
    else passes++;
    total++;
    if (f_gnt !== 3'b001) $display("[TB] FAIL fixed_skip: got %b expected 001", f_gnt);
    else passes++;
    step();
    aux_req = 3'b000;
  endtask

  task automatic test_aux_preempt();
    obs_t got, exp;
    op_t  o, junk;
    o    = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_2000};
    junk = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd0, addr: 32'h5555_5555};
    step();
    apply_stimulus(o);
    step();
    apply_stimulus(junk);
    aux_req = 3'b010;
    for (int c = 0; c < 2; c++) begin
      sb.push_back(aux_exp(1, 1'b1, 1'b1));
      @(negedge clk_core);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) $display("[TB] FAIL preempt_c%0d: got %h expected %h", c, got, exp);
      else passes++;
      step();
    end
    aux_req = 3'b000;
    go_idle();
    sb.push_back(model(o));
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL preempt_issue: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_mem1_stall();
    obs_t got, exp, held;
    op_t  o, junk;
    o    = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_4000};
    junk = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd0, addr: 32'h7777_7777};
    held = model(o);
    held.stall = 1'b1; held.valid = 1'b0; held.dc_read = 1'b0;
    step();
    apply_stimulus(o);
    step();
    apply_stimulus(junk);
    mem1_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sb.push_back(held);
      @(negedge clk_core);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) $display("[TB] FAIL mem1_stall_c%0d: got %h expected %h", c, got, exp);
      else passes++;
      step();
    end
    mem1_stall = 1'b0;
    go_idle();
    sb.push_back(model(o));
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL mem1_release: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_kill();
    obs_t got, exp;
    op_t  o, bad;
    o   = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_6000};
    bad = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_6002};
    step();
    apply_stimulus(o);
    step();
    go_idle();
    mem1_stall = 1'b1;
    csr_kill = 1'b1;
    aux_req = 3'b001;
    sb.push_back(aux_exp(0, 1'b1, 1'b0));
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL kill_cycle: got %h expected %h", got, exp);
    else passes++;
    step();
    csr_kill = 1'b0;
    mem1_stall = 1'b0;
    aux_req = 3'b000;
    sb.push_back('0);
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL kill_after: got %h expected %h", got, exp);
    else passes++;
    step();
    apply_stimulus(bad);
    step();
    go_idle();
    csr_kill = 1'b1;
    exp = model(bad);
    exp.exc = 1'b0;
    sb.push_back(exp);
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL kill_exc: got %h expected %h", got, exp);
    else passes++;
    step();
    csr_kill = 1'b0;
    sb.push_back('0);
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL kill_exc_after: got %h expected %h", got, exp);
    else passes++;
  endtask

  task automatic test_reset_midstall();
    obs_t got, exp;
    op_t  o;
    o = '{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_8000};
    step();
    apply_stimulus(o);
    step();
    go_idle();
    mem1_stall = 1'b1;
    aux_req = 3'b001;
    sb.push_back(aux_exp(0, 1'b1, 1'b1));
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL rst_pre: got %h expected %h", got, exp);
    else passes++;
    step();
    reset = 1'b1;
    csr_kill = 1'b1;
    aux_req = 3'b000;
    apply_stimulus('{exc: 1'b0, cause: 4'd0, rd: 1'b1, wr: 1'b0, width: 2'd2, addr: 32'h0000_9000});
    step();
    sb.push_back('0);
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL rst_clear: got %h expected %h", got, exp);
    else passes++;
    step();
    reset = 1'b0;
    csr_kill = 1'b0;
    mem1_stall = 1'b0;
    go_idle();
    aux_req = 3'b111;
    sb.push_back(aux_exp(0, 1'b0, 1'b1));
    @(negedge clk_core);
    exp = sb.pop_front(); got = sample(); total++;
    if (got !== exp) $display("[TB] FAIL rst_rr: got %h expected %h", got, exp);
    else passes++;
    step();
    aux_req = 3'b000;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aux_a[0] = 30'h0000_0100;
    aux_a[1] = 30'h0000_02AB;
    aux_a[2] = 30'h0000_03C4;
    reset = 1'b1;
    aux_req = 3'b000;
    mem1_stall = 1'b0;
    csr_kill = 1'b0;
    csr_satp = SATP;
    go_idle();
    test_reset();
    test_aligned_load();
    test_misalign();
    test_round_robin();
    test_aux_preempt();
    test_mem1_stall();
    test_kill();
    test_reset_midstall();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
